alu_seq_ctrl: RTL and testbench

Multi-cycle arithmetic sequencer for the calculator core. It accepts one operation at a time: ADD, SUB, 8×8 unsigned MUL or 8/8 unsigned DIV. All four run on a single shared 8-bit add/subtract datapath, with MUL as shift-add and DIV as restoring division. It sits between the keypad/command decoder and the display/result registers, and reports completion with a start/busy/done handshake.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/addsub8.sv | 33 +++
 rtl/alu_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic sequencer.
//   - Operation codes presented on the op input.
//   - Sequencer state encoding.
//   - Quotient reported for a divide-by-zero.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] DIV0_QUOT = 8'hFF;

endpackage

// File: rtl/addsub8.sv
// Combinational 8-bit ripple-carry adder with operand-B invert control.
// Ports:
//   x   in  8  operand X
//   y   in  8  operand Y (inverted when inv=1)
//   inv in  1  invert Y; with ci=1 this gives x - y
//   ci  in  1  carry in
//   s   out 8  sum
//   co  out 1  carry out (no-borrow when subtracting)
module addsub8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       inv,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] y_eff;
  logic       c_v;

  assign y_eff = y ^ {8{inv}};

  always_comb begin
    s   = '0;
    c_v = ci;
    for (int i = 0; i < 8; i++) begin
      s[i] = x[i] ^ y_eff[i] ^ c_v;
      c_v  = (x[i] & y_eff[i]) | (c_v & (x[i] ^ y_eff[i]));
    end
    co = c_v;
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle arithmetic sequencer: ADD/SUB (1 RUN cycle), shift-add MUL and
// restoring DIV (8 RUN cycles each), all through one shared addsub8 instance.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, op, a, b     request, operation and operands (latched on acceptance)
//   busy, done          busy from accept until back in IDLE; one-cycle done pulse
//   result_lo/hi        sum/diff | product lo/hi | quotient/remainder
//   carry, err          ADD carry / SUB no-borrow; divide-by-zero flag
module alu_seq_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             err
);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [7:0] acc_q, acc_d;  // MUL accumulator / DIV partial remainder
  logic [7:0] qr_q, qr_d;    // MUL multiplier shift reg / DIV quotient shift reg
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic       carry_q, carry_d, err_q, err_d;

  logic [7:0] add_x, add_y, add_s;
  logic       add_inv, add_ci, add_co;
  logic       div0, run_last;
  logic [7:0] div_shift, mul_s, mul_acc_nxt, mul_q_nxt, div_r_nxt, div_q_nxt;
  logic       mul_c, qbit;

  assign div0      = (op_q == OP_DIV) && (b_q == 8'd0);
  // Divide-by-zero still spends one RUN cycle so its latency matches ADD/SUB.
  assign run_last  = (op_q == OP_ADD) || (op_q == OP_SUB) || div0 || (cnt_q == 3'd0);
  assign div_shift = {acc_q[6:0], qr_q[7]};

  // Adder input steering per operation.
  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_inv = 1'b0;
    add_ci  = 1'b0;
    unique case (op_q)
      OP_ADD: ;
      OP_SUB: begin add_inv = 1'b1; add_ci = 1'b1; end
      OP_MUL: begin add_x = acc_q; add_y = a_q; end
      OP_DIV: begin add_x = div_shift; add_inv = 1'b1; add_ci = 1'b1; end
    endcase
  end

  addsub8 u_addsub8 (
    .x   (add_x),
    .y   (add_y),
    .inv (add_inv),
    .ci  (add_ci),
    .s   (add_s),
    .co  (add_co)
  );

  always_comb begin
    mul_c       = qr_q[0] & add_co;
    mul_s       = qr_q[0] ? add_s : acc_q;
    mul_acc_nxt = {mul_c, mul_s[7:1]};
    mul_q_nxt   = {mul_s[0], qr_q[7:1]};
    // A set remainder MSB means the 9-bit shifted value already exceeds b.
    qbit        = acc_q[7] | add_co;
    div_r_nxt   = qbit ? add_s : div_shift;
    div_q_nxt   = {qr_q[6:0], qbit};
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (run_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    result_lo = res_lo_q;
    result_hi = res_hi_q;
    carry     = carry_q;
    err       = err_q;
  end

  // Datapath next state.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    carry_d  = carry_q;
    err_d    = err_q;
    if (state_q == S_IDLE && start) begin
      op_d     = op;
      a_d      = a;
      b_d      = b;
      acc_d    = 8'd0;
      qr_d     = (op == OP_DIV) ? a : b;
      cnt_d    = 3'd7;
      res_lo_d = 8'd0;
      res_hi_d = 8'd0;
      carry_d  = 1'b0;
      err_d    = 1'b0;
    end else if (state_q == S_RUN) begin
      unique case (op_q)
        OP_ADD, OP_SUB: begin
          res_lo_d = add_s;
          carry_d  = add_co;
        end
        OP_MUL: begin
          acc_d = mul_acc_nxt;
          qr_d  = mul_q_nxt;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            res_hi_d = mul_acc_nxt;
            res_lo_d = mul_q_nxt;
          end
        end
        OP_DIV: begin
          if (div0) begin
            res_lo_d = DIV0_QUOT;
            res_hi_d = a_q;
            err_d    = 1'b1;
          end else begin
            acc_d = div_r_nxt;
            qr_d  = div_q_nxt;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd0) begin
              res_hi_d = div_r_nxt;
              res_lo_d = div_q_nxt;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 2'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      acc_q    <= 8'd0;
      qr_q     <= 8'd0;
      cnt_q    <= 3'd0;
      res_lo_q <= 8'd0;
      res_hi_q <= 8'd0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed and random operations checked
// against an arithmetic reference model, plus handshake and reset scenarios.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       busy, done, carry, err;
  logic [7:0] result_lo, result_hi;

  int total = 0;
  int bad   = 0;

  alu_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .carry     (carry),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {err, carry, hi, lo} straight from the arithmetic definitions.
  function automatic logic [17:0] ref_result(input logic [1:0] o, input logic [7:0] x,
                                             input logic [7:0] y);
    int unsigned sum, prod;
    logic [7:0]  lo, hi;
    logic        c, e;
    lo = 8'd0; hi = 8'd0; c = 1'b0; e = 1'b0;
    case (o)
      2'd0: begin sum = x + y; lo = sum[7:0]; c = sum[8]; end
      2'd1: begin lo = x - y; c = (x >= y); end
      2'd2: begin prod = x * y; lo = prod[7:0]; hi = prod[15:8]; end
      default: begin
        if (y == 8'd0) begin lo = 8'hFF; hi = x; e = 1'b1; end
        else begin lo = x / y; hi = x % y; end
      end
    endcase
    return {e, c, hi, lo};
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [7:0] y);
    if (o == 2'd0 || o == 2'd1 || (o == 2'd3 && y == 8'd0)) return 2;
    return 9;
  endfunction

  // Drive one request and wait (bounded) for done; lat counts cycles from the
  // start-sampling edge to the done sample; busy_all is 1 if busy stayed high.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic busy_all);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    busy_all = busy;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
      busy_all = busy_all & busy;
    end
  endtask

  task automatic test_reset();
    int   lat;
    logic ba;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = 8'd0; b = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, carry, err, result_hi, result_lo} !== 20'd0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {busy, done, carry, err, result_hi, result_lo});
    end
    rst = 1'b0;
    run_op(2'd0, 8'd200, 8'd100, lat, ba);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, carry, err, result_hi, result_lo} !== 20'd0) begin
      bad++;
      $display("FAIL reset_clears got=%h exp=0", {busy, done, carry, err, result_hi, result_lo});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [1:0]  os[$] = '{2'd0, 2'd1, 2'd1};
    logic [7:0]  xs[$] = '{8'd200, 8'd5, 8'd7};
    logic [7:0]  ys[$] = '{8'd100, 8'd7, 8'd5};
    logic [17:0] exp;
    int          lat;
    logic        ba;
    for (int i = 0; i < 12; i++) begin
      os.push_back(2'($urandom_range(0, 1)));
      xs.push_back(8'($urandom)); ys.push_back(8'($urandom));
    end
    for (int i = 0; i < os.size(); i++) begin
      run_op(os[i], xs[i], ys[i], lat, ba);
      exp = ref_result(os[i], xs[i], ys[i]);
      total++;
      if ({err, carry, result_hi, result_lo} !== exp) begin
        bad++;
        $display("FAIL addsub op=%0d a=%0d b=%0d got=%h exp=%h", os[i], xs[i], ys[i],
                 {err, carry, result_hi, result_lo}, exp);
      end
      total++;
      if (lat != ref_latency(os[i], ys[i]) || ba !== 1'b1) begin
        bad++;
        $display("FAIL addsub_latency got=%0d busy=%b exp=%0d busy=1", lat, ba,
                 ref_latency(os[i], ys[i]));
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || {err, carry, result_hi, result_lo} !== exp) begin
        bad++;
        $display("FAIL addsub_hold done=%b busy=%b got=%h exp=%h", done, busy,
                 {err, carry, result_hi, result_lo}, exp);
      end
    end
  endtask

  task automatic test_mul();
    logic [7:0]  xs[$] = '{8'd255, 8'd13, 8'd0};
    logic [7:0]  ys[$] = '{8'd255, 8'd11, 8'd77};
    logic [17:0] exp;
    int          lat;
    logic        ba;
    for (int i = 0; i < 10; i++) begin
      xs.push_back(8'($urandom)); ys.push_back(8'($urandom));
    end
    for (int i = 0; i < xs.size(); i++) begin
      run_op(2'd2, xs[i], ys[i], lat, ba);
      exp = ref_result(2'd2, xs[i], ys[i]);
      total++;
      if ({err, carry, result_hi, result_lo} !== exp) begin
        bad++;
        $display("FAIL mul %0d*%0d got=%h exp=%h", xs[i], ys[i],
                 {err, carry, result_hi, result_lo}, exp);
      end
      total++;
      if (lat != 9 || ba !== 1'b1) begin
        bad++;
        $display("FAIL mul_latency got=%0d busy=%b exp=9 busy=1", lat, ba);
      end
    end
  endtask

  task automatic test_div();
    logic [7:0]  xs[$] = '{8'd200, 8'd255, 8'd3, 8'd42, 8'd128};
    logic [7:0]  ys[$] = '{8'd7, 8'd1, 8'd200, 8'd0, 8'd255};
    logic [17:0] exp;
    int          lat;
    logic        ba;
    for (int i = 0; i < 10; i++) begin
      xs.push_back(8'($urandom)); ys.push_back(8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < xs.size(); i++) begin
      run_op(2'd3, xs[i], ys[i], lat, ba);
      exp = ref_result(2'd3, xs[i], ys[i]);
      total++;
      if ({err, carry, result_hi, result_lo} !== exp) begin
        bad++;
        $display("FAIL div %0d/%0d got=%h exp=%h", xs[i], ys[i],
                 {err, carry, result_hi, result_lo}, exp);
      end
      total++;
      if (lat != ref_latency(2'd3, ys[i]) || ba !== 1'b1) begin
        bad++;
        $display("FAIL div_latency b=%0d got=%0d busy=%b exp=%0d", ys[i], lat, ba,
                 ref_latency(2'd3, ys[i]));
      end
    end
  endtask

  task automatic test_ignore_start();
    int   lat;
    logic ba;
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 8'd13; b = 8'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'd0; a = 8'd1; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 9 || {result_hi, result_lo} !== 16'd143) begin
      bad++;
      $display("FAIL ignore_start lat=%0d got=%0d exp lat=9 val=143", lat,
               {result_hi, result_lo});
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || {result_hi, result_lo} !== 16'd143) begin
      bad++;
      $display("FAIL ignore_start_not_queued busy=%b got=%0d exp busy=0 val=143", busy,
               {result_hi, result_lo});
    end
    run_op(2'd0, 8'd1, 8'd1, lat, ba);
    total++;
    if (result_lo !== 8'd2) begin
      bad++;
      $display("FAIL ignore_start_followup got=%0d exp=2", result_lo);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    int   lat;
    logic ba;
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 8'd255; b = 8'd255;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_before got=%b exp=1", busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, carry, err, result_hi, result_lo} !== 20'd0) begin
      bad++;
      $display("FAIL abort_async got=%h exp=0", {busy, done, carry, err, result_hi, result_lo});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done got=%b exp=0", seen);
    end
    run_op(2'd0, 8'd1, 8'd1, lat, ba);
    total++;
    if (result_lo !== 8'd2 || lat != 2) begin
      bad++;
      $display("FAIL abort_followup got=%0d lat=%0d exp=2 lat=2", result_lo, lat);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic ba;
    run_op(2'd2, 8'd20, 8'd20, lat, ba);
    // Hold start from the done cycle: ignored there, accepted in the next IDLE cycle.
    start = 1'b1; op = 2'd0; a = 8'd1; b = 8'd1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle busy=%b done=%b exp 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept busy=%b exp=1", busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || result_lo !== 8'd2 || result_hi !== 8'd0) begin
      bad++;
      $display("FAIL b2b_result done=%b got=%0d/%0d exp done=1 2/0", done, result_lo, result_hi);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
